// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM.
// Holds the state encoding, the opcode/funct constants decoded by the
// controller, and the 3-bit ALU operation codes driven onto alucontrol.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        JALEX   = 4'd12,
        JREX    = 4'd13
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// R-type ALU decoder: maps funct to an ALU operation and flags whether the
// funct is one of the supported arithmetic/logic ops (jr is handled apart).
// Ports: funct in; alucontrol out (add when not legal); legal out.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       legal
);

    always_comb begin
        alucontrol = ALU_ADD;
        legal      = 1'b1;
        case (funct)
            F_ADD:   alucontrol = ALU_ADD;
            F_SUB:   alucontrol = ALU_SUB;
            F_AND:   alucontrol = ALU_AND;
            F_OR:    alucontrol = ALU_OR;
            F_SLT:   alucontrol = ALU_SLT;
            default: legal      = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: fetch/decode/execute sequencing of a shared
// memory datapath with a mem_ready handshake and a bounded wait timeout.
// Ports: clk, reset (async, active-high); op/funct/zero/mem_ready in;
// datapath mux selects, write enables and instr_done/illegal/mem_err pulses out.
module mc_controller
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    state_t          state, state_next;
    logic [TO_W-1:0] cnt, cnt_next;
    logic [2:0]      dec_alu;
    logic            dec_legal;
    logic            mem_wait;
    logic            timeout;

    mc_aludec u_aludec (
        .funct      (funct),
        .alucontrol (dec_alu),
        .legal      (dec_legal)
    );

    // Only the three memory-access states wait on mem_ready.
    assign mem_wait = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !mem_ready;
    // mem_ready on the limit cycle wins because mem_wait is then false.
    assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (cnt == TO_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Count only consecutive wait cycles in the same state; an abort clears it
    // even when it lands back in FETCH.
    always_comb begin
        cnt_next = '0;
        if (mem_wait && !timeout && (state_next == state))
            cnt_next = cnt + TO_W'(1);
    end

    always_comb begin
        state_next = state;
        pcen       = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        instr_done = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;

        case (state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                if (mem_ready) begin
                    state_next = DECODE;
                end else if (timeout) begin
                    mem_err    = 1'b1;
                    state_next = FETCH;
                end
            end
            DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE: begin
                        if (funct == F_JR)
                            state_next = JREX;
                        else if (dec_legal)
                            state_next = RTYPEEX;
                        else begin
                            illegal    = 1'b1;
                            state_next = FETCH;
                        end
                    end
                    OP_BEQ:  state_next = BEQEX;
                    OP_ADDI: state_next = ADDIEX;
                    OP_J:    state_next = JEX;
                    OP_JAL:  state_next = JALEX;
                    default: begin
                        illegal    = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready) begin
                    state_next = MEMWB;
                end else if (timeout) begin
                    mem_err    = 1'b1;
                    state_next = FETCH;
                end
            end
            MEMWB: begin
                memtoreg   = 2'b01;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_next = FETCH;
                end else if (timeout) begin
                    mem_err    = 1'b1;
                    state_next = FETCH;
                end
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = dec_alu;
                state_next = ALUWB;
            end
            ALUWB: begin
                regdst     = 2'b01;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = zero;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            JEX: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            JALEX: begin
                // PC already holds old PC+4, which becomes the link value.
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                regdst     = 2'b10;
                memtoreg   = 2'b10;
                regwrite   = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            JREX: begin
                pcsrc      = 2'b11;
                pcen       = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase

        // Strobes are forced low for as long as reset is held.
        if (reset) begin
            pcen       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
            mem_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller (MEM_TIMEOUT=4): walks each instruction
// class cycle by cycle and compares the full control word against
// hand-written expectations, including timeout and mid-access reset.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       pcen, iord, memwrite, irwrite, regwrite, alusrca;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       instr_done, illegal, mem_err;
    logic [19:0] ctrl;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_controller #(.MEM_TIMEOUT(4), .TO_W(3)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .instr_done(instr_done),
        .illegal(illegal), .mem_err(mem_err)
    );

    assign ctrl = {pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg,
                   alusrca, alusrcb, pcsrc, alucontrol, instr_done, illegal, mem_err};

    function automatic logic [19:0] mk(input logic pe, io, mw, iw, rw,
                                       input logic [1:0] rd, mt,
                                       input logic sa,
                                       input logic [1:0] sb, ps,
                                       input logic [2:0] ac,
                                       input logic dn, il, er);
        return {pe, io, mw, iw, rw, rd, mt, sa, sb, ps, ac, dn, il, er};
    endfunction

    task automatic check(input string tag, input logic [19:0] exp);
        checks++;
        assert (ctrl === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, ctrl, exp);
        end
    endtask

    // Check current cycle's outputs, then advance one clock.
    task automatic step(input string tag, input logic [19:0] exp);
        #1;
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    logic [19:0] e_f_rdy, e_f_wait, e_f_err, e_dec, e_dec_ill, e_madr, e_mrd, e_mrd_err;
    logic [19:0] e_mwb, e_mwr_w, e_mwr_d, e_aluwb, e_beq1, e_beq0, e_addiex, e_addiwb;
    logic [19:0] e_j, e_jal, e_jr;
    logic [5:0]  rfun [5];
    logic [2:0]  ralu [5];

    initial begin
        //               pe io mw iw rw rd     mt     sa sb     ps     ac      dn il er
        e_f_rdy   = mk(1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 3'b010, 0, 0, 0);
        e_f_wait  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 3'b010, 0, 0, 0);
        e_f_err   = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 3'b010, 0, 0, 1);
        e_dec     = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 3'b010, 0, 0, 0);
        e_dec_ill = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 3'b010, 0, 1, 0);
        e_madr    = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 3'b010, 0, 0, 0);
        e_mrd     = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b010, 0, 0, 0);
        e_mrd_err = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b010, 0, 0, 1);
        e_mwb     = mk(0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 3'b010, 1, 0, 0);
        e_mwr_w   = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b010, 0, 0, 0);
        e_mwr_d   = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b010, 1, 0, 0);
        e_aluwb   = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 3'b010, 1, 0, 0);
        e_beq1    = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 3'b110, 1, 0, 0);
        e_beq0    = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 3'b110, 1, 0, 0);
        e_addiex  = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 3'b010, 0, 0, 0);
        e_addiwb  = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 3'b010, 1, 0, 0);
        e_j       = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b10, 3'b010, 1, 0, 0);
        e_jal     = mk(1, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 2'b10, 3'b010, 1, 0, 0);
        e_jr      = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b11, 3'b010, 1, 0, 0);
        rfun[0] = 6'b100000; ralu[0] = 3'b010;
        rfun[1] = 6'b100010; ralu[1] = 3'b110;
        rfun[2] = 6'b100100; ralu[2] = 3'b000;
        rfun[3] = 6'b100101; ralu[3] = 3'b001;
        rfun[4] = 6'b101010; ralu[4] = 3'b111;

        // Reset: strobes low even with mem_ready high.
        reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        #1 check("reset", e_f_wait);
        mem_ready = 1'b1;
        #1 check("reset_gate", e_f_wait);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // lw, zero-wait: 5 cycles
        op = 6'b100011; mem_ready = 1'b1;
        step("lw_fetch", e_f_rdy);
        step("lw_dec", e_dec);
        step("lw_madr", e_madr);
        step("lw_mrd", e_mrd);
        step("lw_mwb", e_mwb);

        // sw with 3 wait cycles in MEMWR
        op = 6'b101011;
        step("sw_fetch", e_f_rdy);
        step("sw_dec", e_dec);
        step("sw_madr", e_madr);
        mem_ready = 1'b0;
        step("sw_wait1", e_mwr_w);
        step("sw_wait2", e_mwr_w);
        step("sw_wait3", e_mwr_w);
        mem_ready = 1'b1;
        step("sw_done", e_mwr_d);

        // R-type add/sub/and/or/slt: 4 cycles each
        op = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            funct = rfun[i];
            step("rt_fetch", e_f_rdy);
            step("rt_dec", e_dec);
            step("rt_ex", mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b00, ralu[i], 0, 0, 0));
            step("rt_wb", e_aluwb);
        end

        // beq taken / not taken: 3 cycles each
        op = 6'b000100; zero = 1'b1;
        step("beq1_fetch", e_f_rdy);
        step("beq1_dec", e_dec);
        step("beq1_ex", e_beq1);
        zero = 1'b0;
        step("beq0_fetch", e_f_rdy);
        step("beq0_dec", e_dec);
        step("beq0_ex", e_beq0);

        // addi
        op = 6'b001000;
        step("addi_fetch", e_f_rdy);
        step("addi_dec", e_dec);
        step("addi_ex", e_addiex);
        step("addi_wb", e_addiwb);

        // j, jal, jr
        op = 6'b000010;
        step("j_fetch", e_f_rdy);
        step("j_dec", e_dec);
        step("j_ex", e_j);
        op = 6'b000011;
        step("jal_fetch", e_f_rdy);
        step("jal_dec", e_dec);
        step("jal_ex", e_jal);
        op = 6'b000000; funct = 6'b001000;
        step("jr_fetch", e_f_rdy);
        step("jr_dec", e_dec);
        step("jr_ex", e_jr);

        // Illegal op, then illegal R-type funct
        op = 6'b111111;
        step("ill_op_fetch", e_f_rdy);
        step("ill_op_dec", e_dec_ill);
        op = 6'b000000; funct = 6'b000000;
        step("ill_fn_fetch", e_f_rdy);
        step("ill_fn_dec", e_dec_ill);

        // lw timeout in MEMRD: error on 5th wait cycle, then FETCH
        op = 6'b100011;
        step("to_fetch", e_f_rdy);
        step("to_dec", e_dec);
        step("to_madr", e_madr);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("to_mrd_wait", e_mrd);
        step("to_mrd_err", e_mrd_err);
        // Back in FETCH; keep starving it to hit the fetch timeout too.
        for (int i = 0; i < 4; i++) step("fto_wait", e_f_wait);
        step("fto_err", e_f_err);
        step("fto_retry", e_f_wait);
        mem_ready = 1'b1;
        op = 6'b000010;
        step("fto_fetch", e_f_rdy);
        step("fto_dec", e_dec);
        step("fto_j", e_j);

        // sw: mem_ready arriving on the limit cycle wins over the timeout
        op = 6'b101011;
        step("lim_fetch", e_f_rdy);
        step("lim_dec", e_dec);
        step("lim_madr", e_madr);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("lim_wait", e_mwr_w);
        mem_ready = 1'b1;
        step("lim_done", e_mwr_d);

        // Reset in the middle of MEMWR
        step("rst_fetch", e_f_rdy);
        step("rst_dec", e_dec);
        step("rst_madr", e_madr);
        mem_ready = 1'b0;
        step("rst_mwr", e_mwr_w);
        reset = 1'b1;
        #1 check("rst_async", e_f_wait);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ready = 1'b1;
        step("rst_after_fetch", e_f_rdy);
        step("rst_after_dec", e_dec);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
